// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding unit: writeback mux codes and register index width.
package hazard_pkg;

    localparam int REG_IDX_W = 5;

    localparam logic [1:0] WB_MUX_RES  = 2'b00;
    localparam logic [1:0] WB_MUX_LOAD = 2'b01;
    localparam logic [1:0] WB_MUX_RET  = 2'b10;

    // An EX-stage producer whose result is an ALU result or a load has no data ready yet.
    function automatic logic ex_result_pending(input logic [1:0] mux);
        return (mux == WB_MUX_RES) || (mux == WB_MUX_LOAD);
    endfunction

endpackage

// File: rtl/hz_scoreboard.sv
// Long-latency operation scoreboard: busy bit per register, outstanding count, full flag, sticky error.
module hz_scoreboard
    import hazard_pkg::*;
#(
    parameter int LO_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue,
    input  logic [REG_IDX_W-1:0] issue_rd,
    input  logic                 done,
    input  logic [REG_IDX_W-1:0] done_rd,
    output logic [31:0]          busy,
    output logic                 full,
    output logic                 err
);

    logic [3:0]  count_q, count_d;
    logic [31:0] busy_q, busy_d;
    logic        err_q, err_d;
    logic        issue_ok, done_ok;

    assign full = (count_q == 4'(LO_MAX));
    assign busy = busy_q;
    assign err  = err_q;

    // Next-state: completion clears first, then issue sets so a same-register issue wins.
    always_comb begin
        issue_ok = issue && (issue_rd != '0) && !full;
        done_ok  = done && busy_q[done_rd];
        busy_d   = busy_q;
        count_d  = count_q;
        err_d    = err_q;
        if (done_ok) begin
            busy_d[done_rd] = 1'b0;
        end
        if (issue_ok) begin
            busy_d[issue_rd] = 1'b1;
        end
        if (issue_ok && !done_ok) begin
            count_d = count_q + 4'd1;
        end else if (done_ok && !issue_ok) begin
            count_d = count_q - 4'd1;
        end
        if ((issue && full) || (done && !busy_q[done_rd])) begin
            err_d = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // State register; reset drops all in-flight operations and any request in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: rtl/hazard_sb.sv
// Data hazard detection and operand forwarding for the ID stage, backed by a long-op scoreboard.
module hazard_sb
    import hazard_pkg::*;
#(
    parameter int NRS    = 2,
    parameter int XLEN   = 32,
    parameter int LO_MAX = 4,
    parameter int FWD_EN = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NRS-1:0]             i_hz_rs,
    input  logic [NRS*REG_IDX_W-1:0]   i_rs,
    input  logic [NRS*XLEN-1:0]        i_rs_raw_d,
    input  logic                       i_hz_rd,
    input  logic [REG_IDX_W-1:0]       i_rd,
    input  logic [REG_IDX_W-1:0]       i_ex_wb_reg,
    input  logic [REG_IDX_W-1:0]       i_ma_wb_reg,
    input  logic [REG_IDX_W-1:0]       i_wb_wb_reg,
    input  logic                       i_ex_wb_en,
    input  logic                       i_ma_wb_en,
    input  logic                       i_wb_wb_en,
    input  logic [1:0]                 i_ex_wb_mux,
    input  logic [1:0]                 i_ma_wb_mux,
    input  logic [XLEN-1:0]            i_ex_ret,
    input  logic [XLEN-1:0]            i_ma_res,
    input  logic [XLEN-1:0]            i_ma_rd_dat,
    input  logic [XLEN-1:0]            i_ma_ret,
    input  logic [XLEN-1:0]            i_wb_wb_d,
    input  logic                       i_lo_issue,
    input  logic [REG_IDX_W-1:0]       i_lo_rd,
    input  logic                       i_lo_done,
    input  logic [REG_IDX_W-1:0]       i_lo_done_rd,
    input  logic [XLEN-1:0]            i_lo_dat,
    output logic [NRS*XLEN-1:0]        o_rs_d,
    output logic                       o_hz_data,
    output logic                       o_lo_full,
    output logic                       o_err
);

    logic [31:0]    busy;
    logic [NRS-1:0] port_hz;
    logic [XLEN-1:0] ma_data;
    logic           waw_hz;
    logic           full_issue_hz;

    hz_scoreboard #(
        .LO_MAX(LO_MAX)
    ) u_scoreboard (
        .clk     (i_clk),
        .rst     (i_rst),
        .issue   (i_lo_issue),
        .issue_rd(i_lo_rd),
        .done    (i_lo_done),
        .done_rd (i_lo_done_rd),
        .busy    (busy),
        .full    (o_lo_full),
        .err     (o_err)
    );

    // Select which MA-stage value would be written back, shared by every read port.
    always_comb begin
        ma_data = i_ma_res;
        case (i_ma_wb_mux)
            WB_MUX_LOAD: ma_data = i_ma_rd_dat;
            WB_MUX_RET:  ma_data = i_ma_ret;
            default:     ma_data = i_ma_res;
        endcase
    end

    for (genvar k = 0; k < NRS; k++) begin : g_port
        logic [REG_IDX_W-1:0] rs;
        logic [XLEN-1:0]      raw;
        logic [XLEN-1:0]      fwd;
        logic [XLEN-1:0]      data;
        logic                 valid, ex_hit, ma_hit, wb_hit, lo_hit, hz;

        assign rs  = i_rs[REG_IDX_W*k +: REG_IDX_W];
        assign raw = i_rs_raw_d[XLEN*k +: XLEN];

        // Youngest producer wins; a completing long op can be bypassed in the same cycle.
        always_comb begin
            valid  = i_hz_rs[k] && (rs != '0);
            ex_hit = valid && i_ex_wb_en && (i_ex_wb_reg == rs);
            ma_hit = valid && i_ma_wb_en && (i_ma_wb_reg == rs);
            wb_hit = valid && i_wb_wb_en && (i_wb_wb_reg == rs);
            lo_hit = valid && i_lo_done && (i_lo_done_rd == rs);
            if (ex_hit) begin
                fwd = i_ex_ret;
            end else if (ma_hit) begin
                fwd = ma_data;
            end else if (wb_hit) begin
                fwd = i_wb_wb_d;
            end else if (lo_hit) begin
                fwd = i_lo_dat;
            end else begin
                fwd = raw;
            end
            if (FWD_EN != 0) begin
                data = fwd;
                hz   = (ex_hit && ex_result_pending(i_ex_wb_mux)) ||
                       (valid && busy[rs] && !lo_hit);
            end else begin
                data = raw;
                hz   = ex_hit || ma_hit || wb_hit || (valid && busy[rs]);
            end
        end

        assign o_rs_d[XLEN*k +: XLEN] = data;
        assign port_hz[k]             = hz;
    end

    assign waw_hz        = i_hz_rd && (i_rd != '0) && busy[i_rd];
    assign full_issue_hz = i_lo_issue && o_lo_full;
    assign o_hz_data     = (|port_hz) || waw_hz || full_issue_hz;

endmodule

// File: tb/tb_hazard_sb.sv
// Testbench for hazard_sb: forwarding table, directed scoreboard sequences, randomized model check.
module tb_hazard_sb;
    import hazard_pkg::*;

    localparam int NRS    = 2;
    localparam int XLEN   = 32;
    localparam int LO_MAX = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [NRS-1:0]      hz_rs;
    logic [NRS*5-1:0]    rs;
    logic [NRS*XLEN-1:0] raw;
    logic                hz_rd;
    logic [4:0]          rd, ex_reg, ma_reg, wb_reg, lo_rd, lo_done_rd;
    logic                ex_en, ma_en, wb_en, lo_issue, lo_done;
    logic [1:0]          ex_mux, ma_mux;
    logic [XLEN-1:0]     ex_ret, ma_res, ma_rd_dat, ma_ret, wb_d, lo_dat;

    logic [NRS*XLEN-1:0] rs_d_f, rs_d_s;
    logic                hz_f, full_f, err_f, hz_s, full_s, err_s;

    int tests = 0;
    int fails = 0;

    bit m_busy[32];
    int m_count;
    bit m_err;

    hazard_sb #(.NRS(NRS), .XLEN(XLEN), .LO_MAX(LO_MAX), .FWD_EN(1)) dut_f (
        .i_clk(clk), .i_rst(rst), .i_hz_rs(hz_rs), .i_rs(rs), .i_rs_raw_d(raw),
        .i_hz_rd(hz_rd), .i_rd(rd), .i_ex_wb_reg(ex_reg), .i_ma_wb_reg(ma_reg),
        .i_wb_wb_reg(wb_reg), .i_ex_wb_en(ex_en), .i_ma_wb_en(ma_en), .i_wb_wb_en(wb_en),
        .i_ex_wb_mux(ex_mux), .i_ma_wb_mux(ma_mux), .i_ex_ret(ex_ret), .i_ma_res(ma_res),
        .i_ma_rd_dat(ma_rd_dat), .i_ma_ret(ma_ret), .i_wb_wb_d(wb_d), .i_lo_issue(lo_issue),
        .i_lo_rd(lo_rd), .i_lo_done(lo_done), .i_lo_done_rd(lo_done_rd), .i_lo_dat(lo_dat),
        .o_rs_d(rs_d_f), .o_hz_data(hz_f), .o_lo_full(full_f), .o_err(err_f)
    );

    hazard_sb #(.NRS(NRS), .XLEN(XLEN), .LO_MAX(LO_MAX), .FWD_EN(0)) dut_s (
        .i_clk(clk), .i_rst(rst), .i_hz_rs(hz_rs), .i_rs(rs), .i_rs_raw_d(raw),
        .i_hz_rd(hz_rd), .i_rd(rd), .i_ex_wb_reg(ex_reg), .i_ma_wb_reg(ma_reg),
        .i_wb_wb_reg(wb_reg), .i_ex_wb_en(ex_en), .i_ma_wb_en(ma_en), .i_wb_wb_en(wb_en),
        .i_ex_wb_mux(ex_mux), .i_ma_wb_mux(ma_mux), .i_ex_ret(ex_ret), .i_ma_res(ma_res),
        .i_ma_rd_dat(ma_rd_dat), .i_ma_ret(ma_ret), .i_wb_wb_d(wb_d), .i_lo_issue(lo_issue),
        .i_lo_rd(lo_rd), .i_lo_done(lo_done), .i_lo_done_rd(lo_done_rd), .i_lo_dat(lo_dat),
        .o_rs_d(rs_d_s), .o_hz_data(hz_s), .o_lo_full(full_s), .o_err(err_s)
    );

    typedef struct {
        logic [4:0]  rs0;
        logic        ex_en;
        logic [4:0]  ex_reg;
        logic [1:0]  ex_mux;
        logic        ma_en;
        logic [4:0]  ma_reg;
        logic [1:0]  ma_mux;
        logic        wb_en;
        logic [4:0]  wb_reg;
        logic        exp_hz_f;
        logic [31:0] exp_d_f;
        logic        exp_hz_s;
    } vec_t;

    vec_t vecs[12];

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clearInputs();
        rst = 1'b0; hz_rs = '0; rs = '0; raw = {32'hB0, 32'hA0};
        hz_rd = 1'b0; rd = '0;
        ex_reg = '0; ma_reg = '0; wb_reg = '0; ex_en = 1'b0; ma_en = 1'b0; wb_en = 1'b0;
        ex_mux = WB_MUX_RES; ma_mux = WB_MUX_RES;
        ex_ret = 32'h22; ma_res = 32'h11; ma_rd_dat = 32'h33; ma_ret = 32'h44; wb_d = 32'h55;
        lo_issue = 1'b0; lo_rd = '0; lo_done = 1'b0; lo_done_rd = '0; lo_dat = 32'h0;
    endtask

    // Expected result of one read port, from the priority and hazard rules directly.
    function automatic void expPort(input int k, input bit fwd, output logic [31:0] d, output bit h);
        logic [4:0] r;
        bit v, ex_m, ma_m, wb_m, lo_m;
        r    = rs[5*k +: 5];
        v    = hz_rs[k] && (r != 0);
        ex_m = v && ex_en && (ex_reg == r);
        ma_m = v && ma_en && (ma_reg == r);
        wb_m = v && wb_en && (wb_reg == r);
        lo_m = v && lo_done && (lo_done_rd == r);
        d    = raw[32*k +: 32];
        h    = 1'b0;
        if (!fwd) begin
            h = ex_m || ma_m || wb_m || (v && m_busy[r]);
        end else begin
            if (ex_m) d = ex_ret;
            else if (ma_m) d = (ma_mux == 2'b01) ? ma_rd_dat : (ma_mux == 2'b10) ? ma_ret : ma_res;
            else if (wb_m) d = wb_d;
            else if (lo_m) d = lo_dat;
            h = (ex_m && (ex_mux == 2'b00 || ex_mux == 2'b01)) || (v && m_busy[r] && !lo_m);
        end
    endfunction

    task automatic checkOutput();
        logic [63:0] exp_f, exp_s;
        logic [31:0] d;
        bit h, hzf, hzs, common;
        hzf = 1'b0; hzs = 1'b0;
        for (int k = 0; k < NRS; k++) begin
            expPort(k, 1'b1, d, h); exp_f[32*k +: 32] = d; hzf |= h;
            expPort(k, 1'b0, d, h); exp_s[32*k +: 32] = d; hzs |= h;
        end
        common = (hz_rd && rd != 0 && m_busy[rd]) || (lo_issue && m_count == LO_MAX);
        cmp("hz_fwd", 64'(hz_f), 64'(hzf | common));
        cmp("hz_stall", 64'(hz_s), 64'(hzs | common));
        cmp("data_fwd", rs_d_f, exp_f);
        cmp("data_stall", rs_d_s, exp_s);
        cmp("full", {62'd0, full_s, full_f}, {62'd0, m_count == LO_MAX, m_count == LO_MAX});
        cmp("err", {62'd0, err_s, err_f}, {62'd0, m_err, m_err});
    endtask

    // Reference scoreboard update applied for the upcoming clock edge.
    task automatic modelStep();
        bit was_full, iss, dn;
        if (rst) begin
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_count = 0;
            m_err   = 1'b0;
            return;
        end
        was_full = (m_count == LO_MAX);
        iss = lo_issue && (lo_rd != 0) && !was_full;
        dn  = lo_done && m_busy[lo_done_rd];
        if ((lo_issue && was_full) || (lo_done && !m_busy[lo_done_rd])) m_err = 1'b1;
        if (dn) begin m_busy[lo_done_rd] = 1'b0; m_count--; end
        if (iss) begin m_busy[lo_rd] = 1'b1; m_count++; end
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic endCycle();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        applyStimulus();
        endCycle();
    endtask

    task automatic doReset();
        clearInputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic issueOne(input logic [4:0] r);
        clearInputs();
        lo_issue = 1'b1; lo_rd = r;
        cycle();
    endtask

    initial begin
        int bq[$];
        clearInputs();
        rst = 1'b1;
        m_count = 0; m_err = 1'b0;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        @(posedge clk); #1;
        // reset state observed while reset is still held
        cycle();
        cmp("reset_full", 64'(full_f), 64'd0);
        cmp("reset_err", 64'(err_f), 64'd0);
        rst = 1'b0;

        vecs[0]  = '{5'd7, 1'b1, 5'd7, 2'b00, 1'b1, 5'd7, 2'b00, 1'b0, 5'd0, 1'b1, 32'h22, 1'b1};
        vecs[1]  = '{5'd7, 1'b1, 5'd7, 2'b10, 1'b1, 5'd7, 2'b00, 1'b0, 5'd0, 1'b0, 32'h22, 1'b1};
        vecs[2]  = '{5'd7, 1'b1, 5'd7, 2'b01, 1'b0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b1, 32'h22, 1'b1};
        vecs[3]  = '{5'd7, 1'b0, 5'd0, 2'b00, 1'b1, 5'd7, 2'b00, 1'b0, 5'd0, 1'b0, 32'h11, 1'b1};
        vecs[4]  = '{5'd7, 1'b0, 5'd0, 2'b00, 1'b1, 5'd7, 2'b01, 1'b0, 5'd0, 1'b0, 32'h33, 1'b1};
        vecs[5]  = '{5'd7, 1'b0, 5'd0, 2'b00, 1'b1, 5'd7, 2'b10, 1'b0, 5'd0, 1'b0, 32'h44, 1'b1};
        vecs[6]  = '{5'd7, 1'b0, 5'd0, 2'b00, 1'b0, 5'd0, 2'b00, 1'b1, 5'd7, 1'b0, 32'h55, 1'b1};
        vecs[7]  = '{5'd0, 1'b1, 5'd0, 2'b00, 1'b1, 5'd0, 2'b00, 1'b1, 5'd0, 1'b0, 32'hA0, 1'b0};
        vecs[8]  = '{5'd7, 1'b1, 5'd3, 2'b00, 1'b1, 5'd3, 2'b00, 1'b1, 5'd3, 1'b0, 32'hA0, 1'b0};
        vecs[9]  = '{5'd7, 1'b0, 5'd7, 2'b00, 1'b0, 5'd0, 2'b00, 1'b1, 5'd7, 1'b0, 32'h55, 1'b1};
        vecs[10] = '{5'd3, 1'b0, 5'd0, 2'b00, 1'b0, 5'd0, 2'b00, 1'b1, 5'd3, 1'b0, 32'h55, 1'b1};
        vecs[11] = '{5'd7, 1'b0, 5'd0, 2'b00, 1'b1, 5'd7, 2'b10, 1'b1, 5'd7, 1'b0, 32'h44, 1'b1};

        foreach (vecs[i]) begin
            clearInputs();
            hz_rs = 2'b01; rs = {5'd0, vecs[i].rs0};
            ex_en = vecs[i].ex_en; ex_reg = vecs[i].ex_reg; ex_mux = vecs[i].ex_mux;
            ma_en = vecs[i].ma_en; ma_reg = vecs[i].ma_reg; ma_mux = vecs[i].ma_mux;
            wb_en = vecs[i].wb_en; wb_reg = vecs[i].wb_reg;
            applyStimulus();
            cmp($sformatf("vec%0d_hz_fwd", i), 64'(hz_f), 64'(vecs[i].exp_hz_f));
            cmp($sformatf("vec%0d_d_fwd", i), 64'(rs_d_f[31:0]), 64'(vecs[i].exp_d_f));
            cmp($sformatf("vec%0d_hz_stall", i), 64'(hz_s), 64'(vecs[i].exp_hz_s));
            cmp($sformatf("vec%0d_d_stall", i), 64'(rs_d_s[31:0]), 64'h0A0);
            endCycle();
        end

        // long op on r5 stalls a reader until the completion bypasses it
        doReset();
        issueOne(5'd5);
        clearInputs(); hz_rs = 2'b01; rs = {5'd0, 5'd5};
        applyStimulus();
        cmp("lo_busy_stall", 64'(hz_f), 64'd1);
        endCycle();
        clearInputs(); hz_rs = 2'b01; rs = {5'd0, 5'd5};
        lo_done = 1'b1; lo_done_rd = 5'd5; lo_dat = 32'hDEADBEEF;
        applyStimulus();
        cmp("lo_bypass_hz", 64'(hz_f), 64'd0);
        cmp("lo_bypass_data", 64'(rs_d_f[31:0]), 64'hDEADBEEF);
        endCycle();

        // fill to capacity, then an extra issue is refused
        doReset();
        for (int r = 1; r <= 4; r++) issueOne(5'(r));
        clearInputs(); lo_issue = 1'b1; lo_rd = 5'd6;
        applyStimulus();
        cmp("full_at_max", 64'(full_f), 64'd1);
        cmp("full_issue_hz", 64'(hz_f), 64'd1);
        endCycle();
        clearInputs(); hz_rd = 1'b1; rd = 5'd6;
        applyStimulus();
        cmp("full_kept", 64'(full_f), 64'd1);
        cmp("overflow_err", 64'(err_f), 64'd1);
        cmp("rejected_not_busy", 64'(hz_f), 64'd0);
        endCycle();

        // issue and done on the same busy register
        doReset();
        issueOne(5'd9);
        clearInputs(); lo_issue = 1'b1; lo_rd = 5'd9; lo_done = 1'b1; lo_done_rd = 5'd9;
        cycle();
        clearInputs(); hz_rs = 2'b10; rs = {5'd9, 5'd0};
        applyStimulus();
        cmp("same_rd_busy", 64'(hz_f), 64'd1);
        endCycle();
        issueOne(5'd20);
        issueOne(5'd21);
        clearInputs();
        applyStimulus();
        cmp("same_rd_count3", 64'(full_f), 64'd0);
        endCycle();
        issueOne(5'd22);
        clearInputs();
        applyStimulus();
        cmp("same_rd_count4", 64'(full_f), 64'd1);
        endCycle();

        // reset with three in flight (plus an issue on the reset cycle) empties everything
        doReset();
        for (int r = 1; r <= 3; r++) issueOne(5'(r));
        clearInputs(); rst = 1'b1; lo_issue = 1'b1; lo_rd = 5'd4;
        cycle();
        clearInputs(); hz_rs = 2'b11; rs = {5'd2, 5'd1}; hz_rd = 1'b1; rd = 5'd3;
        applyStimulus();
        cmp("post_reset_hz", 64'(hz_f), 64'd0);
        cmp("post_reset_full", 64'(full_f), 64'd0);
        endCycle();
        for (int r = 10; r <= 12; r++) issueOne(5'(r));
        clearInputs();
        applyStimulus();
        cmp("post_reset_count3", 64'(full_f), 64'd0);
        endCycle();

        // randomized traffic against the reference model
        doReset();
        for (int n = 0; n < 600; n++) begin
            clearInputs();
            rst       = ($urandom_range(0, 59) == 0);
            hz_rs     = 2'($urandom_range(0, 3));
            rs        = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            raw       = {$urandom, $urandom};
            hz_rd     = 1'($urandom_range(0, 1));
            rd        = 5'($urandom_range(0, 7));
            ex_en     = 1'($urandom_range(0, 1));
            ma_en     = 1'($urandom_range(0, 1));
            wb_en     = 1'($urandom_range(0, 1));
            ex_reg    = 5'($urandom_range(0, 7));
            ma_reg    = 5'($urandom_range(0, 7));
            wb_reg    = 5'($urandom_range(0, 7));
            ex_mux    = 2'($urandom_range(0, 2));
            ma_mux    = 2'($urandom_range(0, 2));
            ex_ret    = $urandom; ma_res = $urandom; ma_rd_dat = $urandom;
            ma_ret    = $urandom; wb_d = $urandom; lo_dat = $urandom;
            lo_issue  = ($urandom_range(0, 2) == 0);
            lo_rd     = 5'($urandom_range(0, 7));
            lo_done   = ($urandom_range(0, 2) == 0);
            bq.delete();
            for (int i = 1; i < 32; i++) if (m_busy[i]) bq.push_back(i);
            if (bq.size() > 0 && $urandom_range(0, 9) != 0)
                lo_done_rd = 5'(bq[$urandom_range(0, bq.size() - 1)]);
            else
                lo_done_rd = 5'($urandom_range(0, 7));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
